mem_port_arbiter: RTL and testbench

- Shares the single word-addressed data memory (sync write, combinational read, byte address divided by 4) between two requesters: port 0 = instruction fetch, port 1 = data load/store.
- Round-robin arbitration, req/ack handshake, registered read data.
- Programmable wait states so the same controller drives slower memory models.
- Sits between the multicycle CPU control/datapath and the memory.

---
 rtl/mem_port_arbiter_pkg.sv | 8 +
 rtl/rr_arb2.sv | 13 +
 rtl/mem_port_arbiter.sv | 99 +++++++++
 tb/tb_mem_port_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared encodings and limits for the memory port arbiter
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_e;
  localparam int PORT_IF = 0;
  localparam int PORT_DATA = 1;
  localparam int MAX_WAIT_CYCLES = 15;
  localparam int CNT_W = 4;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; a tie goes to the port not served last
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic [1:0] excl_i,
  input  logic       last_i,
  output logic       grant_valid_o,
  output logic       grant_idx_o
);
  logic [1:0] elig;
  assign elig = req_i & ~excl_i;
  assign grant_valid_o = |elig;
  assign grant_idx_o = &elig ? ~last_i : elig[1];
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one word memory between the fetch and load/store ports
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WAIT_CYCLES = 0,
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          Req0,
  input  logic [AW-1:0] Addr0,
  input  logic          WE0,
  input  logic [DW-1:0] WData0,
  output logic          Ack0,
  output logic [DW-1:0] RData0,
  input  logic          Req1,
  input  logic [AW-1:0] Addr1,
  input  logic          WE1,
  input  logic [DW-1:0] WData1,
  output logic          Ack1,
  output logic [DW-1:0] RData1,
  output logic [AW-1:0] MemAddr,
  output logic [DW-1:0] MemWData,
  output logic          MemRead,
  output logic          MemWrite,
  input  logic [DW-1:0] MemRData,
  output logic          Busy,
  output logic          Grant
);
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > MAX_WAIT_CYCLES) begin : g_bad_wait
    $error("WAIT_CYCLES must be within 0..%0d", MAX_WAIT_CYCLES);
  end
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic last_q, last_d, grant_q, grant_d, we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [1:0] excl;
  logic gv, gi, take, done;
  // In RESP the port being acked still holds Req, so it sits out this round
  assign excl = state_q == RESP ? (grant_q == 1'(PORT_DATA) ? 2'b10 : 2'b01) : 2'b00;
  assign take = gv && state_q != ACCESS;
  assign done = state_q == ACCESS && cnt_q == '0;
  rr_arb2 u_arb (
    .req_i        ({Req1, Req0}),
    .excl_i       (excl),
    .last_i       (last_q),
    .grant_valid_o(gv),
    .grant_idx_o  (gi)
  );
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      grant_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      grant_q  <= grant_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end
  always_comb begin
    state_d = take ? ACCESS : state_q == ACCESS ? (done ? RESP : ACCESS) : IDLE;
    cnt_d = take ? CNT_INIT : (state_q == ACCESS && !done) ? cnt_q - CNT_W'(1) : cnt_q;
    last_d = take ? gi : last_q;
    grant_d = take ? gi : grant_q;
    we_d = take ? (gi ? WE1 : WE0) : we_q;
    addr_d = take ? (gi ? Addr1 : Addr0) : addr_q;
    wdata_d = take ? (gi ? WData1 : WData0) : wdata_q;
    rdata0_d = (done && !we_q && grant_q == 1'(PORT_IF)) ? MemRData : rdata0_q;
    rdata1_d = (done && !we_q && grant_q == 1'(PORT_DATA)) ? MemRData : rdata1_q;
  end
  always_comb begin
    MemRead = state_q == ACCESS && !we_q;
    MemWrite = done && we_q;
    Ack0 = state_q == RESP && grant_q == 1'(PORT_IF);
    Ack1 = state_q == RESP && grant_q == 1'(PORT_DATA);
    Busy = state_q == ACCESS || state_q == RESP;
  end
  assign MemAddr = addr_q;
  assign MemWData = wdata_q;
  assign Grant = grant_q;
  assign RData0 = rdata0_q;
  assign RData1 = rdata1_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: arbiters with 0, 2 and 3 wait states checked against a transaction-level model
module tb_mem_port_arbiter;
  localparam int N = 3;
  localparam int WV [N] = '{0, 2, 3};
  logic clk = 1'b0, rst = 1'b1, chk_on = 1'b0;
  always #5 clk = ~clk;
  logic req0 [N], req1 [N], we0 [N], we1 [N];
  logic [31:0] addr0 [N], addr1 [N], wd0 [N], wd1 [N];
  logic ack0 [N], ack1 [N], mrd [N], mwr [N], busy [N], grant [N];
  logic [31:0] rd0 [N], rd1 [N], maddr [N], mwdata [N], mrdata [N];
  logic pk_en = 1'b0;
  int pk_i = 0;
  logic [5:0] pk_idx = '0;
  logic [31:0] pk_v = '0;
  int n_chk = 0, n_fail = 0;

  for (genvar i = 0; i < N; i++) begin : g_dut
    logic [31:0] mem [64];
    mem_port_arbiter #(.WAIT_CYCLES(WV[i]), .AW(32), .DW(32)) dut (
      .Clk(clk), .Rst(rst),
      .Req0(req0[i]), .Addr0(addr0[i]), .WE0(we0[i]), .WData0(wd0[i]), .Ack0(ack0[i]), .RData0(rd0[i]),
      .Req1(req1[i]), .Addr1(addr1[i]), .WE1(we1[i]), .WData1(wd1[i]), .Ack1(ack1[i]), .RData1(rd1[i]),
      .MemAddr(maddr[i]), .MemWData(mwdata[i]), .MemRead(mrd[i]), .MemWrite(mwr[i]),
      .MemRData(mrdata[i]), .Busy(busy[i]), .Grant(grant[i])
    );
    assign mrdata[i] = mem[maddr[i][7:2]];
    always @(posedge clk)
      if (mwr[i]) mem[maddr[i][7:2]] <= mwdata[i];
      else if (pk_en && pk_i == i) mem[pk_idx] <= pk_v;
  end

  // Reference model: one transaction at a time, tracked by its age since grant
  bit m_act [N], m_prt [N], m_we [N], m_last [N], m_gnt [N];
  int m_age [N];
  logic [31:0] m_ad [N], m_wd [N], m_rd0 [N], m_rd1 [N], m_ma [N], m_mwd [N];
  logic [31:0] xmem [N][64];
  always @(posedge clk) begin
    if (pk_en) xmem[pk_i][pk_idx] = pk_v;
    for (int n = 0; n < N; n++) begin
      if (rst) begin
        m_act[n] = 0; m_age[n] = 0; m_last[n] = 1; m_gnt[n] = 0; m_prt[n] = 0; m_we[n] = 0;
        m_rd0[n] = '0; m_rd1[n] = '0; m_ma[n] = '0; m_mwd[n] = '0;
      end else if (m_act[n] && m_age[n] <= WV[n]) begin
        if (m_age[n] == WV[n]) begin
          if (m_we[n]) xmem[n][m_ad[n][7:2]] = m_wd[n];
          else if (m_prt[n]) m_rd1[n] = xmem[n][m_ad[n][7:2]];
          else m_rd0[n] = xmem[n][m_ad[n][7:2]];
        end
        m_age[n] += 1;
      end else begin
        bit c0, c1, p;
        c0 = req0[n] && !(m_act[n] && !m_prt[n]);
        c1 = req1[n] && !(m_act[n] && m_prt[n]);
        p = (c0 && c1) ? !m_last[n] : c1;
        m_act[n] = c0 || c1;
        if (m_act[n]) begin
          m_age[n] = 0; m_prt[n] = p; m_last[n] = p; m_gnt[n] = p;
          m_we[n] = p ? we1[n] : we0[n];
          m_ad[n] = p ? addr1[n] : addr0[n];
          m_wd[n] = p ? wd1[n] : wd0[n];
          m_ma[n] = m_ad[n]; m_mwd[n] = m_wd[n];
        end
      end
    end
  end

  task automatic cmp(input int n, input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL inst%0d %s: got %h expected %h", n, nm, got, exp);
    end
  endtask

  always @(negedge clk) if (chk_on) for (int n = 0; n < N; n++) begin
    cmp(n, "Busy", 32'(busy[n]), 32'(m_act[n]));
    cmp(n, "MemRead", 32'(mrd[n]), 32'(m_act[n] && m_age[n] <= WV[n] && !m_we[n]));
    cmp(n, "MemWrite", 32'(mwr[n]), 32'(m_act[n] && m_age[n] == WV[n] && m_we[n]));
    cmp(n, "Ack0", 32'(ack0[n]), 32'(m_act[n] && m_age[n] == WV[n] + 1 && !m_prt[n]));
    cmp(n, "Ack1", 32'(ack1[n]), 32'(m_act[n] && m_age[n] == WV[n] + 1 && m_prt[n]));
    cmp(n, "Grant", 32'(grant[n]), 32'(m_gnt[n]));
    cmp(n, "MemAddr", maddr[n], m_ma[n]);
    cmp(n, "MemWData", mwdata[n], m_mwd[n]);
    cmp(n, "RData0", rd0[n], m_rd0[n]);
    cmp(n, "RData1", rd1[n], m_rd1[n]);
  end

  task automatic tick(input int k = 1);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic poke(input int n, input int widx, input logic [31:0] v);
    pk_en = 1'b1; pk_i = n; pk_idx = 6'(widx); pk_v = v;
    tick();
    pk_en = 1'b0;
  endtask

  task automatic wait_ack(input int n, input bit p, input int budget, output int cyc);
    cyc = 0;
    do begin tick(); cyc++; end while (!(p ? ack1[n] : ack0[n]) && cyc < budget);
    if (!(p ? ack1[n] : ack0[n])) begin
      n_chk++; n_fail++;
      $display("FAIL inst%0d ack timeout on port %0d after %0d cycles", n, p, cyc);
    end
  endtask

  task automatic t_single_read();
    req1[0] = 1; addr1[0] = 20; we1[0] = 0;
    tick();
    cmp(0, "t1 MemRead", 32'(mrd[0]), 1);
    cmp(0, "t1 MemAddr", maddr[0], 20);
    cmp(0, "t1 early Ack1", 32'(ack1[0]), 0);
    tick();
    cmp(0, "t1 Ack1", 32'(ack1[0]), 1);
    cmp(0, "t1 RData1", rd1[0], 32'hDEADBEEF);
    cmp(0, "t1 Ack0", 32'(ack0[0]), 0);
    cmp(0, "t1 MemRead in RESP", 32'(mrd[0]), 0);
    req1[0] = 0;
    tick();
    cmp(0, "t1 idle", 32'(busy[0]), 0);
  endtask

  task automatic t_write_read();
    int cyc;
    req1[1] = 1; addr1[1] = 8; we1[1] = 1; wd1[1] = 32'h12345678;
    tick(); cmp(1, "t2 MemWrite c1", 32'(mwr[1]), 0);
    tick(); cmp(1, "t2 MemWrite c2", 32'(mwr[1]), 0);
    tick();
    cmp(1, "t2 MemWrite c3", 32'(mwr[1]), 1);
    cmp(1, "t2 MemAddr", maddr[1], 8);
    cmp(1, "t2 MemWData", mwdata[1], 32'h12345678);
    tick();
    cmp(1, "t2 Ack1 c4", 32'(ack1[1]), 1);
    cmp(1, "t2 MemWrite c4", 32'(mwr[1]), 0);
    req1[1] = 0; req0[1] = 1; addr0[1] = 8; we0[1] = 0;
    wait_ack(1, 0, 12, cyc);
    req0[1] = 0;
    cmp(1, "t2 read latency", cyc, 4);
    cmp(1, "t2 RData0", rd0[1], 32'h12345678);
    cmp(1, "t2 RData1 untouched by write", rd1[1], 0);
    tick();
  endtask

  task automatic t_contend();
    int cyc;
    rst = 1; tick(); rst = 0;
    req0[0] = 1; addr0[0] = 20; we0[0] = 0;
    req1[0] = 1; addr1[0] = 24; we1[0] = 0;
    tick();
    cmp(0, "t3 first grant", 32'(grant[0]), 0);
    cmp(0, "t3 first addr", maddr[0], 20);
    tick();
    cmp(0, "t3 Ack0 c2", 32'(ack0[0]), 1);
    cmp(0, "t3 RData0", rd0[0], 32'hDEADBEEF);
    req0[0] = 0;
    tick();
    cmp(0, "t3 no idle gap", 32'(busy[0]), 1);
    cmp(0, "t3 second grant", 32'(grant[0]), 1);
    cmp(0, "t3 second addr", maddr[0], 24);
    tick();
    cmp(0, "t3 Ack1 c4", 32'(ack1[0]), 1);
    cmp(0, "t3 RData1", rd1[0], 32'h600D600D);
    req1[0] = 0;
    tick();
    cmp(0, "t3 idle", 32'(busy[0]), 0);
    req0[0] = 1; req1[0] = 1;
    tick();
    cmp(0, "t3 next tie grant", 32'(grant[0]), 0);
    wait_ack(0, 0, 10, cyc);
    req0[0] = 0;
    wait_ack(0, 1, 10, cyc);
    req1[0] = 0;
    tick();
  endtask

  task automatic t_starve();
    int acks = 0, c0 = 0, c1 = 0, prev = -1, bad = 0, cyc = 0, first = -1, p;
    req0[0] = 1; req1[0] = 1;
    while (acks < 10 && cyc < 60) begin
      tick(); cyc++;
      if (ack0[0] || ack1[0]) begin
        p = int'(ack1[0]);
        if (p == prev) bad++;
        if (first < 0) first = p;
        prev = p; acks++;
        if (p == 1) c1++; else c0++;
        if (acks == 10) begin req0[0] = 0; req1[0] = 0; end
      end
    end
    cmp(0, "t4 acks", acks, 10);
    cmp(0, "t4 port0 count", c0, 5);
    cmp(0, "t4 port1 count", c1, 5);
    cmp(0, "t4 repeats", bad, 0);
    cmp(0, "t4 first winner", first, 0);
    cmp(0, "t4 cycles", cyc, 20);
    tick();
  endtask

  task automatic t_reset_write();
    int w = 0, a = 0, cyc;
    req0[2] = 1; addr0[2] = 12; we0[2] = 1; wd0[2] = 32'hAAAA5555;
    tick(); w += int'(mwr[2]);
    cmp(2, "t5 busy", 32'(busy[2]), 1);
    tick(); w += int'(mwr[2]);
    rst = 1; req0[2] = 0;
    tick();
    cmp(2, "t5 Busy after rst", 32'(busy[2]), 0);
    cmp(2, "t5 MemAddr after rst", maddr[2], 0);
    cmp(2, "t5 MemWData after rst", mwdata[2], 0);
    cmp(2, "t5 Ack0 after rst", 32'(ack0[2]), 0);
    rst = 0;
    repeat (6) begin w += int'(mwr[2]); a += int'(ack0[2]); tick(); end
    cmp(2, "t5 MemWrite count", w, 0);
    cmp(2, "t5 Ack count", a, 0);
    req0[2] = 1; we0[2] = 0;
    wait_ack(2, 0, 12, cyc);
    req0[2] = 0;
    cmp(2, "t5 word intact", rd0[2], 32'h11111111);
    tick();
  endtask

  task automatic t_withdraw();
    int a = 0;
    req0[1] = 1; addr0[1] = 40; we0[1] = 0;
    tick();
    cmp(1, "t6 granted", 32'(busy[1]), 1);
    req0[1] = 0; addr0[1] = 44;
    tick(2);
    cmp(1, "t6 latched addr", maddr[1], 40);
    cmp(1, "t6 MemRead", 32'(mrd[1]), 1);
    tick();
    cmp(1, "t6 Ack0", 32'(ack0[1]), 1);
    cmp(1, "t6 RData0", rd0[1], 32'hCAFEF00D);
    repeat (4) begin tick(); a += int'(ack0[1]); end
    cmp(1, "t6 extra acks", a, 0);
    cmp(1, "t6 idle", 32'(busy[1]), 0);
  endtask

  initial begin
    for (int n = 0; n < N; n++) begin
      req0[n] = 0; req1[n] = 0; we0[n] = 0; we1[n] = 0;
      addr0[n] = '0; addr1[n] = '0; wd0[n] = '0; wd1[n] = '0;
    end
    tick(2);
    chk_on = 1'b1;
    for (int n = 0; n < N; n++) begin
      cmp(n, "reset Busy", 32'(busy[n]), 0);
      cmp(n, "reset Grant", 32'(grant[n]), 0);
      cmp(n, "reset MemAddr", maddr[n], 0);
      cmp(n, "reset RData0", rd0[n], 0);
    end
    poke(0, 5, 32'hDEADBEEF);
    poke(0, 6, 32'h600D600D);
    poke(1, 10, 32'hCAFEF00D);
    poke(1, 11, 32'h0BADBEEF);
    poke(2, 3, 32'h11111111);
    rst = 0;
    tick();
    t_single_read();
    t_write_read();
    t_contend();
    t_starve();
    t_reset_write();
    t_withdraw();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
